// File: rtl/sprite_anim_ram.sv
// Animated sprite store: NUM_DIRS x NUM_ANIM frames in one synchronous RAM, with a
// vertical-tick animation counter and a two-stage bounds-checked pixel read.
module sprite_anim_ram #(
  parameter int COLOR_W        = 24,
  parameter int SPR_W          = 26,
  parameter int SPR_H          = 26,
  parameter int NUM_DIRS       = 4,
  parameter int NUM_ANIM       = 2,
  parameter int TICKS_PER_ANIM = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 'hFF00FF,
  parameter     INIT_FILE      = "sprite.txt",
  localparam int FRAME_PIX = SPR_W * SPR_H,
  localparam int DEPTH     = NUM_DIRS * NUM_ANIM * FRAME_PIX,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int XW        = $clog2(SPR_W),
  localparam int YW        = $clog2(SPR_H),
  localparam int DW        = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1,
  localparam int AW        = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COLOR_W-1:0] data_In,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic               we,
  input  logic               anim_en,
  input  logic               frame_tick,
  input  logic               rd_req,
  input  logic [DW-1:0]      dir,
  input  logic [XW:0]        px_x,
  input  logic [YW:0]        px_y,
  output logic [AW-1:0]      anim_frame,
  output logic [COLOR_W-1:0] data_Out,
  output logic               opaque,
  output logic               out_valid
);

  localparam int AW1 = ADDR_W + 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int TW  = (TICKS_PER_ANIM > 1) ? $clog2(TICKS_PER_ANIM) : 1;

  logic [COLOR_W-1:0] mem [DEPTH];
  logic [TW-1:0]      tick_cnt;
  logic               dir_ok;
  logic               inb_c;
  logic               wr_ok;
  logic [ADDR_W:0]    addr_c;
  logic [ADDR_W-1:0]  rd_addr;
  logic               vld_p1;
  logic               inb_p1;
  logic [COLOR_W-1:0] rdata_p1;

  // Flat pixel address: frame base (direction group, then animation frame) plus row-major offset.
  function automatic logic [ADDR_W:0] pix_addr(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                               input logic [XW:0] x, input logic [YW:0] y);
    return ((AW1'(d) * AW1'(NUM_ANIM) + AW1'(a)) * AW1'(FRAME_PIX))
           + AW1'(y) * AW1'(SPR_W) + AW1'(x);
  endfunction

  // A direction field that cannot encode an invalid group needs no check.
  if ((1 << DW) > NUM_DIRS) begin : g_dir_chk
    assign dir_ok = (dir < DW'(NUM_DIRS));
  end else begin : g_dir_all
    assign dir_ok = 1'b1;
  end

  always_comb begin
    inb_c   = (px_x < XW1'(SPR_W)) && (px_y < YW1'(SPR_H)) && dir_ok;
    addr_c  = pix_addr(dir, anim_frame, px_x, px_y);
    rd_addr = (inb_c && !addr_c[ADDR_W]) ? addr_c[ADDR_W-1:0] : '0;
    wr_ok   = ({1'b0, write_address} < AW1'(DEPTH));
  end

  // Stage 1: RAM read and write share the edge, so a colliding read sees the old word.
  always_ff @(posedge Clk) begin
    if (we && wr_ok)
      mem[write_address] <= data_In;
    rdata_p1 <= mem[rd_addr];
    inb_p1   <= inb_c;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim_frame <= '0;
      tick_cnt   <= '0;
      vld_p1     <= 1'b0;
      out_valid  <= 1'b0;
      opaque     <= 1'b0;
      data_Out   <= '0;
    end else begin
      if (anim_en && frame_tick) begin
        if (tick_cnt == TW'(TICKS_PER_ANIM - 1)) begin
          tick_cnt   <= '0;
          anim_frame <= (anim_frame == AW'(NUM_ANIM - 1)) ? '0 : anim_frame + AW'(1);
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
      vld_p1    <= rd_req;
      // Stage 2: colour-key and bounds resolve; outputs hold while idle.
      out_valid <= vld_p1;
      if (vld_p1) begin
        data_Out <= inb_p1 ? rdata_p1 : TRANSPARENT;
        opaque   <= inb_p1 && (rdata_p1 != TRANSPARENT);
      end
    end
  end

endmodule
